// File: rtl/mdio_responder_if.sv
// MDIO pin pair plus the responder's access-report outputs.
// The master modport is the management side (or bench); slave is the responder.
interface mdio_responder_if;
  logic        MDC;
  logic        MDIO_in;
  logic        MDIO_out;
  logic        MDIO_oe;
  logic        link_up;
  logic        wr_strobe;
  logic        rd_strobe;
  logic [4:0]  acc_addr;
  logic [15:0] acc_data;
  logic        frame_err;

  modport master (
    output MDC, MDIO_in, link_up,
    input  MDIO_out, MDIO_oe, wr_strobe, rd_strobe, acc_addr, acc_data, frame_err
  );

  modport slave (
    input  MDC, MDIO_in, link_up,
    output MDIO_out, MDIO_oe, wr_strobe, rd_strobe, acc_addr, acc_data, frame_err
  );
endinterface

// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder with an oversampled MDC and a 32x16 register file.
// Every frame bit is taken on a synchronised MDC rising edge; reads are driven back on MDIO.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR     = 5'd1,
  parameter int unsigned PRE_LEN      = 32,
  parameter int unsigned TIMEOUT_CLK  = 1000,
  parameter logic [15:0] PHY_ID1      = 16'h0022,
  parameter logic [15:0] PHY_ID2      = 16'h1622,
  parameter logic [15:0] CTRL_DEFAULT = 16'h1140
) (
  input  logic            clk_100Mz,
  input  logic            reset,
  mdio_responder_if.slave bus
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StSt2   = 3'd1;
  localparam logic [2:0] StOp    = 3'd2;
  localparam logic [2:0] StPhyad = 3'd3;
  localparam logic [2:0] StRegad = 3'd4;
  localparam logic [2:0] StTa    = 3'd5;
  localparam logic [2:0] StData  = 3'd6;

  localparam int unsigned TW      = $clog2(TIMEOUT_CLK + 1);
  localparam logic [TW-1:0] TmoLast = TW'(TIMEOUT_CLK - 1);
  localparam logic [5:0] PreMax  = 6'(PRE_LEN);

  logic mdc_meta_q, mdc_sync_q, mdc_prev_q, mdio_meta_q, mdio_sync_q;
  logic mdc_rise, bit_in;

  logic [2:0]    state_q, state_d;
  logic [5:0]    pre_q, pre_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          op_hi_q, op_hi_d;
  logic          rd_q, rd_d;
  logic          match_q, match_d;
  logic [4:0]    phyad_q, phyad_d;
  logic [4:0]    regad_q, regad_d;
  logic [15:0]   data_q, data_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          oe_q, oe_d, out_q, out_d;
  logic          wr_stb_q, wr_stb_d, rd_stb_q, rd_stb_d, err_q, err_d;
  logic [4:0]    acc_addr_q, acc_addr_d;
  logic [15:0]   acc_data_q, acc_data_d;

  logic [15:0] regs_q [32];
  logic        wr_en;
  logic [15:0] wr_val, rd_val;
  logic [4:0]  reg_idx;
  logic [3:0]  ridx;

  assign mdc_rise = mdc_sync_q & ~mdc_prev_q;
  assign bit_in   = mdio_sync_q;
  assign reg_idx  = {regad_q[3:0], bit_in};
  assign wr_val   = {data_q[14:0], bit_in};
  assign ridx     = 4'd14 - cnt_q;

  // Regs 1..3 are synthesised from live values rather than stored.
  always_comb begin
    rd_val = regs_q[reg_idx];
    if (reg_idx == 5'd1)      rd_val = 16'h7949 | {13'd0, bus.link_up, 2'd0};
    else if (reg_idx == 5'd2) rd_val = PHY_ID1;
    else if (reg_idx == 5'd3) rd_val = PHY_ID2;
  end

  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    cnt_d      = cnt_q;
    op_hi_d    = op_hi_q;
    rd_d       = rd_q;
    match_d    = match_q;
    phyad_d    = phyad_q;
    regad_d    = regad_q;
    data_d     = data_q;
    tmo_d      = tmo_q;
    oe_d       = oe_q;
    out_d      = out_q;
    wr_stb_d   = 1'b0;
    rd_stb_d   = 1'b0;
    err_d      = 1'b0;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    wr_en      = 1'b0;

    if (mdc_rise) begin
      tmo_d = '0;
      case (state_q)
        StIdle: begin
          if (bit_in) begin
            if (pre_q < PreMax) pre_d = pre_q + 6'd1;
          end else if (pre_q >= PreMax) begin
            state_d = StSt2;
            pre_d   = '0;
          end else begin
            pre_d = '0;
          end
        end
        StSt2: begin
          cnt_d   = '0;
          state_d = bit_in ? StOp : StIdle;
        end
        StOp: begin
          if (cnt_q == 4'd0) begin
            op_hi_d = bit_in;
            cnt_d   = 4'd1;
          end else if (op_hi_q != bit_in) begin
            rd_d    = op_hi_q;
            cnt_d   = '0;
            state_d = StPhyad;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end
        StPhyad: begin
          phyad_d = {phyad_q[3:0], bit_in};
          if (cnt_q == 4'd4) begin
            match_d = ({phyad_q[3:0], bit_in} == PHY_ADDR);
            cnt_d   = '0;
            state_d = StRegad;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StRegad: begin
          regad_d = reg_idx;
          if (cnt_q == 4'd4) begin
            cnt_d   = '0;
            state_d = StTa;
            if (match_q && rd_q) data_d = rd_val;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        StTa: begin
          if (cnt_q == 4'd0) begin
            cnt_d = 4'd1;
            if (match_q && rd_q) begin
              oe_d  = 1'b1;
              out_d = 1'b0;
            end
          end else begin
            cnt_d   = '0;
            state_d = StData;
            if (match_q && rd_q) out_d = data_q[15];
          end
        end
        StData: begin
          if (match_q && rd_q) out_d = data_q[ridx];
          else                 data_d = wr_val;
          if (cnt_q == 4'd15) begin
            state_d = StIdle;
            pre_d   = '0;
            oe_d    = 1'b0;
            out_d   = 1'b0;
            if (match_q) begin
              acc_addr_d = regad_q;
              if (rd_q) begin
                rd_stb_d   = 1'b1;
                acc_data_d = data_q;
              end else begin
                wr_en      = 1'b1;
                wr_stb_d   = 1'b1;
                acc_data_d = wr_val;
              end
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        default: state_d = StIdle;
      endcase
    end else if (state_q != StIdle) begin
      if (tmo_q == TmoLast) begin
        state_d = StIdle;
        pre_d   = '0;
        oe_d    = 1'b0;
        out_d   = 1'b0;
        err_d   = 1'b1;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge clk_100Mz or posedge reset) begin
    if (reset) begin
      mdc_meta_q  <= 1'b0;
      mdc_sync_q  <= 1'b0;
      mdc_prev_q  <= 1'b0;
      mdio_meta_q <= 1'b0;
      mdio_sync_q <= 1'b0;
      state_q     <= StIdle;
      pre_q       <= '0;
      cnt_q       <= '0;
      op_hi_q     <= 1'b0;
      rd_q        <= 1'b0;
      match_q     <= 1'b0;
      phyad_q     <= '0;
      regad_q     <= '0;
      data_q      <= '0;
      tmo_q       <= '0;
      oe_q        <= 1'b0;
      out_q       <= 1'b0;
      wr_stb_q    <= 1'b0;
      rd_stb_q    <= 1'b0;
      err_q       <= 1'b0;
      acc_addr_q  <= '0;
      acc_data_q  <= '0;
    end else begin
      mdc_meta_q  <= bus.MDC;
      mdc_sync_q  <= mdc_meta_q;
      mdc_prev_q  <= mdc_sync_q;
      mdio_meta_q <= bus.MDIO_in;
      mdio_sync_q <= mdio_meta_q;
      state_q     <= state_d;
      pre_q       <= pre_d;
      cnt_q       <= cnt_d;
      op_hi_q     <= op_hi_d;
      rd_q        <= rd_d;
      match_q     <= match_d;
      phyad_q     <= phyad_d;
      regad_q     <= regad_d;
      data_q      <= data_d;
      tmo_q       <= tmo_d;
      oe_q        <= oe_d;
      out_q       <= out_d;
      wr_stb_q    <= wr_stb_d;
      rd_stb_q    <= rd_stb_d;
      err_q       <= err_d;
      acc_addr_q  <= acc_addr_d;
      acc_data_q  <= acc_data_d;
    end
  end

  // Reg0 bit 15 is a soft reset: it never lands in storage.
  always_ff @(posedge clk_100Mz or posedge reset) begin
    if (reset) begin
      regs_q[0] <= CTRL_DEFAULT;
      for (int i = 1; i < 32; i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      if (regad_q == 5'd0) begin
        if (wr_val[15]) begin
          regs_q[0] <= CTRL_DEFAULT;
          for (int i = 4; i < 32; i++) regs_q[i] <= '0;
        end else begin
          regs_q[0] <= wr_val;
        end
      end else if (regad_q >= 5'd4) begin
        regs_q[regad_q] <= wr_val;
      end
    end
  end

  assign bus.MDIO_out  = out_q;
  assign bus.MDIO_oe   = oe_q;
  assign bus.wr_strobe = wr_stb_q;
  assign bus.rd_strobe = rd_stb_q;
  assign bus.acc_addr  = acc_addr_q;
  assign bus.acc_data  = acc_data_q;
  assign bus.frame_err = err_q;

endmodule
